// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sac_state_t;

    localparam int SAC_MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell walks WIDTH-bit operands LSB first,
// one bit per clock, then publishes the sum and carry-out with a done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > SAC_MAX_WIDTH) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH out of range");
        end
    endgenerate

    sac_state_t state;
    sac_state_t next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             load;
    logic             last;

    full_adder u_fa (
        .a   (sa[0]),
        .b   (sb[0]),
        .cin (c),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    // A new request is taken from IDLE and also from DONE for back-to-back runs.
    assign load = start && ((state == IDLE) || (state == DONE));
    assign last = (state == RUN) && (cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            sr   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {fa_sum, sr[WIDTH-1:1]};
            c   <= fa_cout;
            cnt <= cnt + 1'b1;
            // Outputs update only on the final bit so they hold through the next run.
            if (last) begin
                sum  <= {fa_sum, sr[WIDTH-1:1]};
                cout <= fa_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expected {cout,sum} come from plain
// integer addition and are checked by a monitor whenever done pulses.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int passCount = 0;
    int totalCount = 0;
    int cycle = 0;
    int doneTotal = 0;
    logic [W:0] expQ[$];
    logic [W:0] held = '0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int total;
        total = int'(x) + int'(y) + int'(ci);
        return (W+1)'(total % (1 << (W + 1)));
    endfunction

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a = x;
        b = y;
        cin = ci;
        start = 1'b1;
        expQ.push_back(model(x, y, ci));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the first negedge after acceptance; n counts negedges up to done.
    task automatic waitDone(output int n, output int busyN);
        n = 1;
        busyN = 0;
        while (!done && n < 60) begin
            if (busy) busyN++;
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput("done timeout", 32'(done), 32'd1);
    endtask

    // Monitor: pops the scoreboard on done, otherwise checks the result is held.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            held = '0;
        end else if (done) begin
            doneTotal++;
            if (expQ.size() == 0) begin
                checkOutput("spurious done", 32'(done), 32'd0);
            end else begin
                held = expQ.pop_front();
                checkOutput("result", 32'({cout, sum}), 32'(held));
            end
        end else begin
            checkOutput("hold", 32'({cout, sum}), 32'(held));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int busyN;
        int doneCycle[5];
        int doneBefore;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(8'h5A, 8'h3C, 1'b0);
        waitDone(n, busyN);
        checkOutput("busy cycles", 32'(busyN), 32'(W));
        checkOutput("done latency", 32'(n), 32'(W + 1));
        checkOutput("sum 5A+3C", 32'(sum), 32'h96);
        @(negedge clk);
        checkOutput("done one cycle", 32'(done), 32'd0);

        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitDone(n, busyN);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        waitDone(n, busyN);
        applyStimulus(8'h00, 8'h00, 1'b0);
        waitDone(n, busyN);
        @(negedge clk);

        // A start during RUN must not disturb the operands already captured.
        doneBefore = doneTotal;
        applyStimulus(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(n, busyN);
        checkOutput("ignored start sum", 32'(sum), 32'h30);
        repeat (12) @(negedge clk);
        checkOutput("ignored start dones", 32'(doneTotal - doneBefore), 32'd1);

        // Start held: a new operand pair is offered in every done cycle.
        a = 8'h11;
        b = 8'h22;
        cin = 1'b1;
        start = 1'b1;
        expQ.push_back(model(a, b, cin));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            waitDone(n, busyN);
            doneCycle[k] = cycle;
            if (k < 4) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
                expQ.push_back(model(a, b, cin));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 1; k < 5; k++)
            checkOutput("done spacing", 32'(doneCycle[k] - doneCycle[k-1]), 32'(W + 1));
        repeat (3) @(negedge clk);

        // Reset in the middle of a run aborts it and clears the result.
        applyStimulus(8'h77, 8'h66, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort sum", 32'(sum), 32'd0);
        checkOutput("abort cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        doneBefore = doneTotal;
        repeat (20) @(negedge clk);
        checkOutput("no done after reset", 32'(doneTotal - doneBefore), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus(ra, rb, 1'($urandom));
            waitDone(n, busyN);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
